// File: rtl/adder_pkg.sv
// Shared defaults and the chunk-width derivation for the pipelined adder.
package adder_pkg;

    localparam int ADDER_WIDTH_DEF  = 16;
    localparam int ADDER_STAGES_DEF = 4;

    function automatic int adder_chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational W-bit ripple-carry adder; one instance per pipeline stage.
module adder_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);

    always_comb begin
        logic w_c;
        w_c   = i_cin;
        o_sum = '0;
        for (int i = 0; i < W; i++) begin
            o_sum[i] = i_a[i] ^ i_b[i] ^ w_c;
            w_c      = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
        end
        o_cout = w_c;
    end

endmodule

// File: rtl/adder_pipe_nbit.sv
// Pipelined WIDTH-bit adder, one CHUNK-bit ripple add per stage, carry registered between stages.
// Optional signed-overflow output enabled by defining ADDER_OVF_EN.
module adder_pipe_nbit
    import adder_pkg::*;
#(
    parameter int WIDTH  = ADDER_WIDTH_DEF,
    parameter int STAGES = ADDER_STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CHUNK = adder_chunk_width(WIDTH, STAGES);

    if ((WIDTH % STAGES) != 0) begin : g_chk_div
        $error("adder_pipe_nbit: WIDTH (%0d) must be a multiple of STAGES (%0d)", WIDTH, STAGES);
    end
    if (STAGES < 1 || STAGES > WIDTH) begin : g_chk_range
        $error("adder_pipe_nbit: STAGES (%0d) must be in 1..WIDTH", STAGES);
    end

    // Handshake: a beat moves on valid && ready. The whole pipe advances together
    // unless the output beat is presented and refused, so in_ready doubles as the
    // global stage enable and bubbles travel with the data rather than collapsing.
    assign in_ready = !(out_valid && !out_ready);

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int HI = WIDTH - k * CHUNK;   // operand bits not yet consumed

        logic [HI-1:0]          w_a;
        logic [HI-1:0]          w_b;
        logic                   w_c;
        logic                   w_v;
        logic [CHUNK-1:0]       w_cs;
        logic                   w_cc;
        logic [(k+1)*CHUNK-1:0] w_nsum;
        logic [(k+1)*CHUNK-1:0] r_sum;
        logic                   r_v;
        logic                   r_c;

        if (k == 0) begin : g_first
            assign w_a    = a;
            assign w_b    = b;
            assign w_c    = cin;
            assign w_v    = in_valid;
            assign w_nsum = w_cs;
        end else begin : g_next
            assign w_a    = g_stage[k-1].g_fwd.r_a;
            assign w_b    = g_stage[k-1].g_fwd.r_b;
            assign w_c    = g_stage[k-1].r_c;
            assign w_v    = g_stage[k-1].r_v;
            assign w_nsum = {w_cs, g_stage[k-1].r_sum};
        end

        adder_chunk #(.W(CHUNK)) u_chunk (
            .i_a    (w_a[CHUNK-1:0]),
            .i_b    (w_b[CHUNK-1:0]),
            .i_cin  (w_c),
            .o_sum  (w_cs),
            .o_cout (w_cc)
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                r_v   <= 1'b0;
                r_c   <= 1'b0;
                r_sum <= '0;
            end else if (in_ready) begin
                r_v   <= w_v;
                r_c   <= w_cc;
                r_sum <= w_nsum;
            end
        end

        // Upper operand chunks ride along until their stage; they never need reset.
        if (k < STAGES - 1) begin : g_fwd
            logic [HI-CHUNK-1:0] r_a;
            logic [HI-CHUNK-1:0] r_b;
            always_ff @(posedge clk) begin
                if (in_ready) begin
                    r_a <= w_a[HI-1:CHUNK];
                    r_b <= w_b[HI-1:CHUNK];
                end
            end
        end

`ifdef ADDER_OVF_EN
        // The top chunk carries the operand sign bits, so overflow lands with sum.
        if (k == STAGES - 1) begin : g_ovf
            logic r_ovf;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ovf <= 1'b0;
                end else if (in_ready) begin
                    r_ovf <= (w_a[CHUNK-1] == w_b[CHUNK-1]) && (w_cs[CHUNK-1] != w_a[CHUNK-1]);
                end
            end
        end
`endif
    end

    assign out_valid = g_stage[STAGES-1].r_v;
    assign sum       = g_stage[STAGES-1].r_sum;
    assign cout      = g_stage[STAGES-1].r_c;
`ifdef ADDER_OVF_EN
    assign ovf       = g_stage[STAGES-1].g_ovf.r_ovf;
`endif

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// Bench for adder_pipe_nbit: directed vectors on a 16/4 instance, random streams on 16/{1,2,4,16}.
module tb_adder_pipe_nbit;

    localparam int N_RND = 10000;
    localparam int ST_TAB [4] = '{1, 2, 4, 16};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] sum;
    logic        cout;
`ifdef ADDER_OVF_EN
    logic        ovf;
`endif

    int          errors = 0;
    int          checks = 0;
    logic        rnd_go = 1'b0;
    logic [16:0] exp_q[$];

    always #5 clk = ~clk;

    adder_pipe_nbit #(.WIDTH(16), .STAGES(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    // Random-stream instances, one per pipeline depth, each with its own scoreboard.
    for (genvar g = 0; g < 4; g++) begin : g_rnd
        logic        iv = 1'b0;
        logic        ordy = 1'b0;
        logic        ci = 1'b0;
        logic        irdy;
        logic        ov;
        logic        co;
        logic        done = 1'b0;
        logic [15:0] ai = '0;
        logic [15:0] bi = '0;
        logic [15:0] so;
`ifdef ADDER_OVF_EN
        logic        of;
`endif
        logic [16:0] q[$];

        adder_pipe_nbit #(.WIDTH(16), .STAGES(ST_TAB[g])) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (iv),
            .in_ready  (irdy),
            .a         (ai),
            .b         (bi),
            .cin       (ci),
            .out_valid (ov),
            .out_ready (ordy),
            .sum       (so),
            .cout      (co)
`ifdef ADDER_OVF_EN
            ,
            .ovf       (of)
`endif
        );

        initial begin
            int          sent;
            int          recv;
            int          cyc;
            logic        pstall;
            logic [16:0] pval;
            logic [16:0] e;
            sent   = 0;
            recv   = 0;
            cyc    = 0;
            pstall = 1'b0;
            pval   = '0;
            wait (rnd_go);
            while (recv < N_RND && cyc < 40000) begin
                @(negedge clk);
                cyc++;
                ordy = ($urandom_range(3, 0) != 0);
                iv   = (sent < N_RND);
                ai   = 16'($urandom_range(16'hFFFF, 0));
                bi   = 16'($urandom_range(16'hFFFF, 0));
                ci   = 1'($urandom_range(1, 0));
                #1;
                if (pstall) begin
                    checks++;
                    if (ov !== 1'b1 || {co, so} !== pval) begin
                        errors++;
                        $display("FAIL rnd_hold_s%0d: got valid=%b %h want valid=1 %h", ST_TAB[g], ov, {co, so}, pval);
                    end
                end
                if (iv && irdy) begin
                    q.push_back({1'b0, ai} + {1'b0, bi} + {16'b0, ci});
                    sent++;
                end
                if (ov && ordy) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL rnd_extra_s%0d: got beat %h want none", ST_TAB[g], {co, so});
                    end else begin
                        e = q.pop_front();
                        if ({co, so} !== e) begin
                            errors++;
                            $display("FAIL rnd_sum_s%0d: got %h want %h", ST_TAB[g], {co, so}, e);
                        end
                    end
                    recv++;
                end
                pstall = ov && !ordy;
                pval   = {co, so};
            end
            iv   = 1'b0;
            ordy = 1'b1;
            checks++;
            if (recv != N_RND || q.size() != 0) begin
                errors++;
                $display("FAIL rnd_count_s%0d: got recv=%0d left=%0d want recv=%0d left=0", ST_TAB[g], recv, q.size(), N_RND);
            end
            done = 1'b1;
        end
    end

    // Present one beat and count negedges until out_valid shows (4 means accept-to-valid latency 4).
    task automatic send_one(input logic [15:0] ta, input logic [15:0] tb_in, input logic tc, output int lat);
        @(negedge clk);
        in_valid  = 1'b1;
        a         = ta;
        b         = tb_in;
        cin       = tc;
        out_ready = 1'b1;
        lat       = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 20);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL reset_sum: got %h want 0000", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b want 0", cout); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
`ifdef ADDER_OVF_EN
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_zero();
        int lat;
        send_one(16'h0000, 16'h0000, 1'b0, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL zero_latency: got %0d want 4", lat); end
        checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL zero_sum: got %h want 0000", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL zero_cout: got %b want 0", cout); end
    endtask

    task automatic test_carry_ripple();
        int lat;
        send_one(16'hFFFF, 16'h0001, 1'b0, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL ripple_latency: got %0d want 4", lat); end
        checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL ripple_sum: got %h want 0000", sum); end
        checks++; if (cout !== 1'b1) begin errors++; $display("FAIL ripple_cout: got %b want 1", cout); end
    endtask

    task automatic test_patterns();
        int lat;
        send_one(16'hFFFF, 16'hFFFF, 1'b1, lat);
        checks++; if (sum !== 16'hFFFF) begin errors++; $display("FAIL allones_sum: got %h want FFFF", sum); end
        checks++; if (cout !== 1'b1) begin errors++; $display("FAIL allones_cout: got %b want 1", cout); end
        send_one(16'h0101, 16'h0011, 1'b0, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL mixed_latency: got %0d want 4", lat); end
        checks++; if (sum !== 16'h0112) begin errors++; $display("FAIL mixed_sum: got %h want 0112", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL mixed_cout: got %b want 0", cout); end
    endtask

    task automatic test_backpressure();
        int          sent = 0;
        int          recv = 0;
        int          held = 0;
        int          cyc = 0;
        logic        started = 1'b0;
        logic [16:0] e;
        exp_q.delete();
        while (recv < 6 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (out_valid && !started) started = 1'b1;
            out_ready = !(started && held < 5);
            in_valid  = (sent < 6);
            a         = 16'(sent + 1);
            b         = 16'h0010;
            cin       = 1'b0;
            #1;
            if (!out_ready) begin
                held++;
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
                checks++; if (out_valid !== 1'b1 || sum !== 16'h0011) begin errors++; $display("FAIL bp_hold: got valid=%b sum=%h want valid=1 sum=0011", out_valid, sum); end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({1'b0, a} + {1'b0, b});
                sent++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bp_extra: got beat %h want none", {cout, sum});
                end else begin
                    e = exp_q.pop_front();
                    if ({cout, sum} !== e) begin errors++; $display("FAIL bp_order: got %h want %h", {cout, sum}, e); end
                end
                recv++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (recv != 6 || held != 5 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_count: got recv=%0d held=%0d left=%0d want recv=6 held=5 left=0", recv, held, exp_q.size());
        end
    endtask

    task automatic test_reset_midop();
        int lat;
        int stale = 0;
        out_ready = 1'b1;
        @(negedge clk); in_valid = 1'b1; a = 16'h1111; b = 16'h0000; cin = 1'b0;
        @(negedge clk); a = 16'h2222;
        @(negedge clk); a = 16'h3333;
        @(negedge clk); in_valid = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
        repeat (8) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        checks++; if (stale !== 0) begin errors++; $display("FAIL rst_mid_stale: got %0d beats want 0", stale); end
        send_one(16'h0A0A, 16'h0505, 1'b1, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL rst_mid_latency: got %0d want 4", lat); end
        checks++; if (sum !== 16'h0F10) begin errors++; $display("FAIL rst_mid_sum: got %h want 0F10", sum); end
    endtask

`ifdef ADDER_OVF_EN
    task automatic test_ovf();
        int lat;
        send_one(16'h7FFF, 16'h0001, 1'b0, lat);
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_pos: got %b want 1", ovf); end
        checks++; if (sum !== 16'h8000) begin errors++; $display("FAIL ovf_pos_sum: got %h want 8000", sum); end
        send_one(16'h8000, 16'hFFFF, 1'b0, lat);
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_neg: got %b want 1", ovf); end
        checks++; if (cout !== 1'b1) begin errors++; $display("FAIL ovf_neg_cout: got %b want 1", cout); end
        send_one(16'h0001, 16'h0001, 1'b0, lat);
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_none: got %b want 0", ovf); end
    endtask
`endif

    task automatic test_random();
        int cyc = 0;
        rnd_go = 1'b1;
        while (!(g_rnd[0].done && g_rnd[1].done && g_rnd[2].done && g_rnd[3].done) && cyc < 60000) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!(g_rnd[0].done && g_rnd[1].done && g_rnd[2].done && g_rnd[3].done)) begin
            errors++;
            $display("FAIL rnd_timeout: got unfinished streams after %0d cycles want all done", cyc);
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_carry_ripple();
        test_patterns();
        test_backpressure();
        test_reset_midop();
`ifdef ADDER_OVF_EN
        test_ovf();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
